// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares a single-port framebuffer between the display line prefetcher and a
// pixel writer. A line fetch bursts LINE_WORDS reads into one bank of a
// ping-pong line buffer. Fetch has strict priority; the writer gets idle cycles.
//
// Ports
//   clk, arst_n        : clock, asynchronous active-low reset
//   fetch_start/_line  : line fetch request pulse and line index
//   fetch_busy/_done   : fetch in progress / line fully written (pulse)
//   fetch_err          : request rejected (busy or line out of range), pulse
//   wr_req/_addr/_data : writer request, held until wr_ack
//   wr_ack             : write issued to memory (pulse)
//   mem_addr/_we/_wdata: registered memory command
//   mem_rdata          : read data, valid the cycle after the address
//   lb_we/_addr/_data  : line buffer write port, lb_addr = {bank, word index}
//
// state  | meaning
// IDLE   | no fetch; writer may be granted
// FETCH  | issuing reads base+1 .. base+LINE_WORDS-1 (base+0 issued on accept)
// DRAIN  | last read in flight; fetch_done/last lb write follow one cycle later
module vga_fb_arbiter #(
    parameter int LINE_WORDS = 160,
    parameter int LINES      = 480,
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 32
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        fetch_start,
    input  logic [9:0]                  fetch_line,
    output logic                        fetch_busy,
    output logic                        fetch_done,
    output logic                        fetch_err,
    input  logic                        wr_req,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        wr_ack,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_we,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        lb_we,
    output logic [$clog2(LINE_WORDS):0] lb_addr,
    output logic [DATA_W-1:0]           lb_data
);
    localparam int IW = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       i_q, i_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                bank_q, bank_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                wr_ack_q, wr_ack_d;
    logic                rd_vld_q, rd_vld_d;
    logic [IW-1:0]       rd_idx_q, rd_idx_d;
    logic                lb_we_q, lb_we_d;
    logic [IW:0]         lb_addr_q, lb_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                line_ok;
    logic                accept;
    logic                grant;
    logic [ADDR_W-1:0]   line_base;

    assign line_ok   = ({22'd0, fetch_line} < 32'(LINES));
    assign accept    = (state_q == S_IDLE) && fetch_start && line_ok;
    // A write may share the cycle of a rejected fetch request, but never
    // directly follows its own ack.
    assign grant     = (state_q == S_IDLE) && !accept && wr_req && !wr_ack_q;
    assign line_base = ADDR_W'(fetch_line) * ADDR_W'(LINE_WORDS);

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_FETCH;
            S_FETCH: if (i_q == IW'(LINE_WORDS - 1)) state_d = S_DRAIN;
            S_DRAIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        i_d         = i_q;
        base_d      = base_q;
        bank_d      = bank_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        wr_ack_d    = 1'b0;
        rd_vld_d    = 1'b0;
        rd_idx_d    = rd_idx_q;
        err_d       = fetch_start && !accept;
        done_d      = (state_q == S_DRAIN);
        // Busy stays high through the cycle that carries fetch_done.
        busy_d      = (state_d != S_IDLE) || (state_q == S_DRAIN);
        // Line buffer write trails each presented read by one cycle.
        lb_we_d     = rd_vld_q;
        lb_addr_d   = rd_vld_q ? {bank_q, rd_idx_q} : lb_addr_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    base_d     = line_base;
                    bank_d     = fetch_line[0];
                    mem_addr_d = line_base;
                    rd_vld_d   = 1'b1;
                    rd_idx_d   = '0;
                    i_d        = IW'(1);
                end else if (grant) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wr_addr;
                    mem_wdata_d = wr_data;
                    wr_ack_d    = 1'b1;
                end
            end
            S_FETCH: begin
                mem_addr_d = base_q + ADDR_W'(i_q);
                rd_vld_d   = 1'b1;
                rd_idx_d   = i_q;
                if (i_q == IW'(LINE_WORDS - 1)) begin
                    i_d = '0;
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            i_q         <= '0;
            base_q      <= '0;
            bank_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            wr_ack_q    <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_idx_q    <= '0;
            lb_we_q     <= 1'b0;
            lb_addr_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            i_q         <= i_d;
            base_q      <= base_d;
            bank_q      <= bank_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            wr_ack_q    <= wr_ack_d;
            rd_vld_q    <= rd_vld_d;
            rd_idx_q    <= rd_idx_d;
            lb_we_q     <= lb_we_d;
            lb_addr_q   <= lb_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign fetch_busy = busy_q;
    assign fetch_done = done_q;
    assign fetch_err  = err_q;
    assign wr_ack     = wr_ack_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign lb_we      = lb_we_q;
    assign lb_addr    = lb_addr_q;
    // The line buffer captures memory read data directly; forced to zero when
    // no line buffer write is in progress so reset leaves every output at 0.
    assign lb_data    = lb_we_q ? mem_rdata : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;
    logic        clk = 1'b0;
    logic        arst_n;
    logic        fetch_start;
    logic [9:0]  fetch_line;
    logic        fetch_busy, fetch_done, fetch_err;
    logic        wr_req;
    logic [16:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        lb_we;
    logic [8:0]  lb_addr;
    logic [31:0] lb_data;

    int n_err = 0;
    int n_chk = 0;

    vga_fb_arbiter dut (
        .clk(clk), .arst_n(arst_n),
        .fetch_start(fetch_start), .fetch_line(fetch_line),
        .fetch_busy(fetch_busy), .fetch_done(fetch_done), .fetch_err(fetch_err),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data)
    );

    always #5 clk = ~clk;

    // Synchronous memory model: read data echoes the address of the previous cycle.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) mem_rdata <= '0;
        else         mem_rdata <= 32'(mem_addr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"},  64'(fetch_busy), 0);
        chk({tag, " done"},  64'(fetch_done), 0);
        chk({tag, " err"},   64'(fetch_err),  0);
        chk({tag, " ack"},   64'(wr_ack),     0);
        chk({tag, " we"},    64'(mem_we),     0);
        chk({tag, " addr"},  64'(mem_addr),   0);
        chk({tag, " wdata"}, 64'(mem_wdata),  0);
        chk({tag, " lb_we"}, 64'(lb_we),      0);
        chk({tag, " lb_a"},  64'(lb_addr),    0);
        chk({tag, " lb_d"},  64'(lb_data),    0);
    endtask

    // Caller sets fetch_start/fetch_line; this steps edge 0 and checks cycles
    // 1..last_c. A rejected request is injected so fetch_err lands on err_c;
    // next_line >= 0 issues a back-to-back request during cycle 161.
    task automatic do_fetch(input int line, input int last_c, input int err_c, input int next_line);
        int base;
        int bank;
        string t;
        base = line * 160;
        bank = line % 2;
        step();
        fetch_start = 1'b0;
        for (int c = 1; c <= last_c; c++) begin
            t = $sformatf("L%0d c%0d", line, c);
            chk({t, " busy"}, 64'(fetch_busy), 64'((c >= 1 && c <= 161) ? 1 : 0));
            chk({t, " mem_addr"}, 64'(mem_addr), 64'(base + ((c - 1 < 159) ? c - 1 : 159)));
            chk({t, " mem_we"}, 64'(mem_we), 0);
            chk({t, " wr_ack"}, 64'(wr_ack), 0);
            chk({t, " done"}, 64'(fetch_done), 64'((c == 161) ? 1 : 0));
            chk({t, " err"}, 64'(fetch_err), 64'((c == err_c) ? 1 : 0));
            chk({t, " lb_we"}, 64'(lb_we), 64'((c >= 2 && c <= 161) ? 1 : 0));
            if (c >= 2 && c <= 161) begin
                chk({t, " lb_addr"}, 64'(lb_addr), 64'(bank * 256 + c - 2));
                chk({t, " lb_data"}, 64'(lb_data), 64'(base + c - 2));
            end
            if (c == err_c - 1) begin
                fetch_start = 1'b1;
                fetch_line  = 10'd5;
            end else if (c == 161 && next_line >= 0) begin
                fetch_start = 1'b1;
                fetch_line  = 10'(next_line);
            end else begin
                fetch_start = 1'b0;
            end
            if (c < last_c) step();
        end
    endtask

    initial begin
        arst_n = 1'b0; fetch_start = 1'b0; fetch_line = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        arst_n = 1'b1;
        step();

        // Line 0, full burst plus one idle cycle
        fetch_start = 1'b1; fetch_line = 10'd0;
        do_fetch(0, 162, -1, -1);

        // Last valid line, then an out-of-range request
        step();
        fetch_start = 1'b1; fetch_line = 10'd479;
        do_fetch(479, 161, -1, -1);
        chk("L479 last addr", 64'(mem_addr), 64'd76799);
        fetch_start = 1'b1; fetch_line = 10'd480;
        step();
        fetch_start = 1'b0;
        chk("L480 err", 64'(fetch_err), 1);
        chk("L480 busy", 64'(fetch_busy), 0);
        chk("L480 we", 64'(mem_we), 0);
        chk("L480 addr", 64'(mem_addr), 64'd76799);
        chk("L480 lb_we", 64'(lb_we), 0);
        step();
        chk("L480 err clr", 64'(fetch_err), 0);
        chk("L480 busy2", 64'(fetch_busy), 0);
        chk("L480 addr2", 64'(mem_addr), 64'd76799);

        // Single write, writer drops request on ack
        wr_req = 1'b1; wr_addr = 17'h1234; wr_data = 32'hDEADBEEF;
        step();
        chk("wr1 we", 64'(mem_we), 1);
        chk("wr1 ack", 64'(wr_ack), 1);
        chk("wr1 addr", 64'(mem_addr), 64'h1234);
        chk("wr1 data", 64'(mem_wdata), 64'hDEADBEEF);
        wr_req = 1'b0;
        step();
        chk("wr1 we off", 64'(mem_we), 0);
        chk("wr1 ack off", 64'(wr_ack), 0);
        chk("wr1 data hold", 64'(mem_wdata), 64'hDEADBEEF);
        step();
        chk("wr1 we off2", 64'(mem_we), 0);
        chk("wr1 ack off2", 64'(wr_ack), 0);

        // Back-to-back requests: one write per two cycles
        wr_req = 1'b1; wr_addr = 17'h100; wr_data = 32'hC0DE0000;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("wrs%0d we", k), 64'(mem_we), 1);
            chk($sformatf("wrs%0d ack", k), 64'(wr_ack), 1);
            chk($sformatf("wrs%0d addr", k), 64'(mem_addr), 64'(32'h100 + k));
            chk($sformatf("wrs%0d data", k), 64'(mem_wdata), 64'(32'hC0DE0000 + k));
            if (k < 2) begin
                wr_addr = 17'(32'h100 + k + 1);
                wr_data = 32'hC0DE0000 + 32'(k + 1);
            end else begin
                wr_req = 1'b0;
            end
            step();
            chk($sformatf("wrs%0d gap we", k), 64'(mem_we), 0);
            chk($sformatf("wrs%0d gap ack", k), 64'(wr_ack), 0);
        end

        // Simultaneous fetch and write: fetch wins, write follows fetch_done
        fetch_start = 1'b1; fetch_line = 10'd2;
        wr_req = 1'b1; wr_addr = 17'h55; wr_data = 32'hA5A5A5A5;
        do_fetch(2, 161, -1, -1);
        step();
        chk("prio we", 64'(mem_we), 1);
        chk("prio ack", 64'(wr_ack), 1);
        chk("prio addr", 64'(mem_addr), 64'h55);
        chk("prio data", 64'(mem_wdata), 64'hA5A5A5A5);
        chk("prio busy", 64'(fetch_busy), 0);
        wr_req = 1'b0;
        step();
        chk("prio we off", 64'(mem_we), 0);

        // Request while busy is rejected; back-to-back request accepted
        fetch_start = 1'b1; fetch_line = 10'd3;
        do_fetch(3, 161, 51, 4);
        do_fetch(4, 162, -1, -1);

        // Reset in the middle of a fetch
        step();
        fetch_start = 1'b1; fetch_line = 10'd6;
        do_fetch(6, 80, -1, -1);
        arst_n = 1'b0;
        #1;
        chk_zero("arst now");
        step();
        chk_zero("arst c1");
        step();
        chk_zero("arst c2");
        #3;
        arst_n = 1'b1;
        step();
        chk_zero("post rst");
        fetch_start = 1'b1; fetch_line = 10'd7;
        do_fetch(7, 162, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Arbitrates a single-port framebuffer memory between the display line prefetcher and a pixel writer (drawing engine or CPU). Driven from the VGA timing domain: at the start of each horizontal blank, the timing side requests the next display line. The arbiter then bursts that line from the framebuffer into one bank of a ping-pong line buffer. The writer gets every memory cycle the fetch does not need.

## Interface
Parameters:
- `LINE_WORDS`, 160: memory words per display line (4 pixels/word at 640 px).
- `LINES`, 480: valid display lines.
- `ADDR_W`, 17: framebuffer word address width; must be at least clog2(LINES*LINE_WORDS).
- `DATA_W`, 32: memory word width.

Ports:
- `clk` in 1: pixel-domain clock; the block's only clock.
- `arst_n` in 1: asynchronous, active-low reset.
- `fetch_start` in 1: single-cycle pulse requesting a line fetch.
- `fetch_line` in 10: line index, sampled with `fetch_start`.
- `fetch_busy` out 1: fetch in progress.
- `fetch_done` out 1: single-cycle pulse, line fully written to the line buffer.
- `fetch_err` out 1: single-cycle pulse, request rejected (busy or line out of range).
- `wr_req` in 1: writer request level; held with `wr_addr`/`wr_data` stable until acked.
- `wr_addr` in ADDR_W: writer word address.
- `wr_data` in DATA_W: writer data.
- `wr_ack` out 1: single-cycle pulse, write issued to memory.
- `mem_addr` out ADDR_W: memory address (registered).
- `mem_we` out 1: memory write enable (registered).
- `mem_wdata` out DATA_W: memory write data (registered).
- `mem_rdata` in DATA_W: read data; valid the cycle after the read address is presented.
- `lb_we` out 1: line buffer write enable.
- `lb_addr` out 1+clog2(LINE_WORDS): {bank, word index}; bank = `fetch_line[0]`.
- `lb_data` out DATA_W: line buffer data, equal to the captured `mem_rdata`.

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE, `fetch_start`=1, `fetch_line` < LINES:
  - Latch base = `fetch_line`*LINE_WORDS, computed in ADDR_W bits.
  - Latch bank = `fetch_line[0]`; set index i=0; go to FETCH.
- IDLE, `fetch_start`=1, `fetch_line` >= LINES: pulse `fetch_err` and stay in IDLE. A pending write may be granted in the same cycle.
- `fetch_start` in FETCH or DRAIN: ignored, `fetch_err` pulsed, current fetch unaffected.
- FETCH, each cycle:
  - Present read `mem_addr`=base+i with `mem_we`=0, then increment i.
  - After issuing i=LINE_WORDS-1, go to DRAIN.
- Line buffer capture: the cycle after each read is presented, `lb_we`=1, `lb_addr`={bank, i_prev}, `lb_data`=`mem_rdata`.
- DRAIN lasts one cycle:
  - Performs the last line buffer write.
  - Pulses `fetch_done` in the same cycle.
  - Returns to IDLE.
- Writer grant: only in IDLE, only when `fetch_start`=0 (or rejected), `wr_req`=1 and `wr_ack`=0. On grant, the next cycle has `mem_we`=1, `mem_addr`=`wr_addr`, `mem_wdata`=`wr_data`, `wr_ack`=1.
- The writer must drop `wr_req` or change to a new request in the cycle it sees `wr_ack`. The arbiter never grants while `wr_ack`=1, so writer throughput is at most 1 per 2 cycles.
- Fetch has strict priority. A simultaneous `fetch_start` and `wr_req` selects the fetch, and the write waits until IDLE.
- When not writing, `mem_we`=0 and `mem_wdata` holds its last value.

## Timing
- Reset (asynchronous): state=IDLE, i=0. All outputs 0: `fetch_busy`, `fetch_done`, `fetch_err`, `wr_ack`, `mem_we`, `mem_addr`, `mem_wdata`, `lb_we`, `lb_addr`, `lb_data`.
- Reset mid-fetch aborts the fetch; no `fetch_done` follows.
- Fetch accepted at edge 0:
  - Reads presented at cycles 1..LINE_WORDS.
  - `lb_we` high at cycles 2..LINE_WORDS+1.
  - `fetch_done` at cycle LINE_WORDS+1.
  - `fetch_busy` high at cycles 1..LINE_WORDS+1 inclusive.
  - Next fetch acceptable at edge LINE_WORDS+1, so back-to-back fetches are legal.
- Total fetch occupancy is LINE_WORDS+1 = 161 cycles, which fits the 160-cycle hblank plus the first active pixel. The timing side issues the request for line y+1 at the start of line y's blank.
- Write latency: `wr_req` sampled at edge k gives the memory write and `wr_ack` at cycle k+1. Worst case is a wait of LINE_WORDS+2 cycles behind a fetch.
- Index wraps only by the state change; `mem_addr` never exceeds base+LINE_WORDS-1.

## Test plan
- Reset, then fetch line 0 with `mem_rdata`=address echo:
  - `mem_addr` 0..159 at cycles 1..160.
  - `lb_we` at cycles 2..161 with `lb_addr`={0, 0..159} and `lb_data`=0..159.
  - `fetch_done` at cycle 161.
- Fetch line 479: base 76640, bank 1, last `mem_addr` 76799. Then fetch line 480: `fetch_err` pulses and no memory activity.
- `wr_req` held with addr 0x1234, data 0xDEADBEEF in IDLE: `mem_we`=1 and `wr_ack`=1 for exactly one cycle, no second write. Repeated requests give one write per 2 cycles.
- `fetch_start` and `wr_req` asserted in the same cycle: the read burst occurs first, and the write is issued one cycle after the cycle in which `fetch_done` pulses.
- `fetch_start` at cycle 50 of an active fetch: `fetch_err` pulses and the burst completes unchanged. Back-to-back `fetch_start` at cycle 161 is accepted.
- `arst_n` low at cycle 80 of a fetch: all outputs 0 immediately, no `fetch_done`. A new fetch after release runs normally.
